// File: rtl/cache_pkg.sv
// Shared definitions for the write-back cache controller.
//   state_t     : controller FSM encoding
//   addr_field  : extracts a bit field (tag / index / word) from an address
//   byte_merge  : overlays strobed bytes of new write data onto an old word
// Helpers work on a 64-bit container so they serve any address/data width
// up to 64 bits; callers cast arguments in and results back out.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOOKUP     = 3'd1,
      WRITE_BACK = 3'd2,
      ALLOCATE   = 3'd3,
      FLUSH      = 3'd4,
      FLUSH_NEXT = 3'd5
   } state_t;

   localparam int MAX_W = 64;
   localparam int MAX_B = MAX_W / 8;

   typedef logic [MAX_W-1:0] wide_t;

   function automatic wide_t addr_field(input wide_t addr, input int lsb, input int width);
      wide_t mask;
      mask = (wide_t'(1) << width) - wide_t'(1);
      return (addr >> lsb) & mask;
   endfunction

   function automatic wide_t byte_merge(input wide_t wdata, input wide_t old,
                                        input logic [MAX_B-1:0] wstrb);
      wide_t res;
      res = old;
      for (int b = 0; b < MAX_B; b++) begin
         if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag / valid / dirty / data storage for a direct-mapped cache.
//   clk, rst            : clock, asynchronous active-high reset (valid/dirty only)
//   idx, word           : line index and word-in-line for both read and write
//   line_tag/valid/dirty/data : combinational read of the addressed line/word
//   data_we, wr_data    : write one word (idx, word)
//   tag_we, wr_tag      : write the line tag
//   vd_we, wr_valid, wr_dirty : write the line status bits
module cache_line_store #(
   parameter int IDX_W  = 5,
   parameter int WPL_W  = 2,
   parameter int TAG_W  = 23,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WPL_W-1:0]  word,
   output logic [TAG_W-1:0]  line_tag,
   output logic              line_valid,
   output logic              line_dirty,
   output logic [DATA_W-1:0] line_data,
   input  logic              data_we,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              tag_we,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic              vd_we,
   input  logic              wr_valid,
   input  logic              wr_dirty
);
   localparam int LINES = 1 << IDX_W;
   localparam int WPL   = 1 << WPL_W;

   logic [TAG_W-1:0]  tag_mem [LINES];
   logic [LINES-1:0]  valid_reg;
   logic [LINES-1:0]  dirty_reg;
   logic [DATA_W-1:0] lane_data [WPL];

   // One data array per word position, each with its own write enable.
   generate
      for (genvar gi = 0; gi < WPL; gi++) begin : g_lane
         logic [DATA_W-1:0] lane_mem [LINES];
         always_ff @(posedge clk) begin
            if (data_we && (word == WPL_W'(gi))) lane_mem[idx] <= wr_data;
         end
         assign lane_data[gi] = lane_mem[idx];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (tag_we) tag_mem[idx] <= wr_tag;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
         dirty_reg <= '0;
      end else if (vd_we) begin
         valid_reg[idx] <= wr_valid;
         dirty_reg[idx] <= wr_dirty;
      end
   end

   assign line_tag   = tag_mem[idx];
   assign line_valid = valid_reg[idx];
   assign line_dirty = dirty_reg[idx];
   assign line_data  = lane_data[word];

endmodule

// File: rtl/cache_ctrl_wb.sv
// Direct-mapped, write-back, write-allocate cache controller with burst
// refill/write-back of multi-word lines, byte-strobed writes and flush.
//   iCLK, iRST          : clock, asynchronous active-high reset
//   cpu_*               : single-outstanding CPU request/response port
//   flush, flush_done   : level flush request, one-cycle completion pulse
//   mem_*               : word-wide memory port, request held until mem_ack
module cache_ctrl_wb
   import cache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5,
   parameter int WPL_W  = 2
)(
   input  logic                iCLK,
   input  logic                iRST,
   input  logic                cpu_valid,
   output logic                cpu_ready,
   input  logic                cpu_rw,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   input  logic [DATA_W/8-1:0] cpu_wstrb,
   output logic                cpu_resp_valid,
   output logic [DATA_W-1:0]   cpu_rdata,
   input  logic                flush,
   output logic                flush_done,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);
   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int TAG_W = ADDR_W - IDX_W - WPL_W - OFF_W;

   state_t              state_reg, state_next;
   logic [WPL_W-1:0]    cnt_reg, cnt_next;
   logic [IDX_W-1:0]    flush_idx_reg, flush_idx_next;
   logic                flushing_reg, flushing_next;

   logic [TAG_W-1:0]    req_tag_reg;
   logic [IDX_W-1:0]    req_idx_reg;
   logic [WPL_W-1:0]    req_word_reg;
   logic                req_rw_reg;
   logic [DATA_W-1:0]   req_wdata_reg;
   logic [DATA_W/8-1:0] req_wstrb_reg;

   logic                accept;
   logic [IDX_W-1:0]    st_idx;
   logic [WPL_W-1:0]    st_word;
   logic [TAG_W-1:0]    line_tag;
   logic                line_valid, line_dirty;
   logic [DATA_W-1:0]   line_data;
   logic                data_we, tag_we, vd_we, wr_valid, wr_dirty;
   logic [DATA_W-1:0]   wr_data;
   logic                hit;
   logic [DATA_W-1:0]   merged;
   wide_t               cpu_addr_w;

   assign cpu_addr_w = MAX_W'(cpu_addr);
   // During a flush the scan index addresses the store, otherwise the request.
   assign st_idx  = flushing_reg ? flush_idx_reg : req_idx_reg;
   assign st_word = (state_reg == LOOKUP) ? req_word_reg : cnt_reg;
   assign hit     = line_valid && (line_tag == req_tag_reg);
   assign merged  = DATA_W'(byte_merge(MAX_W'(req_wdata_reg), MAX_W'(line_data),
                                       MAX_B'(req_wstrb_reg)));
   // Ready is withheld while flush is requested so a CPU request is never
   // handshaken in the cycle the flush wins.
   assign cpu_ready = (state_reg == IDLE) && !flush;

   cache_line_store #(
      .IDX_W(IDX_W), .WPL_W(WPL_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
   ) u_store (
      .clk(iCLK), .rst(iRST), .idx(st_idx), .word(st_word),
      .line_tag(line_tag), .line_valid(line_valid), .line_dirty(line_dirty),
      .line_data(line_data), .data_we(data_we), .wr_data(wr_data),
      .tag_we(tag_we), .wr_tag(req_tag_reg), .vd_we(vd_we),
      .wr_valid(wr_valid), .wr_dirty(wr_dirty)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         flush_idx_reg <= '0;
         flushing_reg  <= 1'b0;
         req_tag_reg   <= '0;
         req_idx_reg   <= '0;
         req_word_reg  <= '0;
         req_rw_reg    <= 1'b0;
         req_wdata_reg <= '0;
         req_wstrb_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         flush_idx_reg <= flush_idx_next;
         flushing_reg  <= flushing_next;
         if (accept) begin
            req_tag_reg   <= TAG_W'(addr_field(cpu_addr_w, OFF_W + WPL_W + IDX_W, TAG_W));
            req_idx_reg   <= IDX_W'(addr_field(cpu_addr_w, OFF_W + WPL_W, IDX_W));
            req_word_reg  <= WPL_W'(addr_field(cpu_addr_w, OFF_W, WPL_W));
            req_rw_reg    <= cpu_rw;
            req_wdata_reg <= cpu_wdata;
            req_wstrb_reg <= cpu_wstrb;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      flush_idx_next = flush_idx_reg;
      flushing_next  = flushing_reg;
      accept         = 1'b0;
      data_we        = 1'b0;
      wr_data        = mem_rdata;
      tag_we         = 1'b0;
      vd_we          = 1'b0;
      wr_valid       = 1'b0;
      wr_dirty       = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_rdata      = '0;
      flush_done     = 1'b0;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      case (state_reg)
         IDLE: begin
            if (flush) begin
               state_next     = FLUSH;
               flush_idx_next = '0;
               flushing_next  = 1'b1;
            end else if (cpu_valid) begin
               accept     = 1'b1;
               state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            cnt_next = '0;
            if (hit) begin
               cpu_resp_valid = 1'b1;
               state_next     = IDLE;
               if (req_rw_reg) begin
                  data_we  = 1'b1;
                  wr_data  = merged;
                  vd_we    = 1'b1;
                  wr_valid = 1'b1;
                  wr_dirty = 1'b1;
               end else begin
                  cpu_rdata = line_data;
               end
            end else if (line_valid && line_dirty) begin
               state_next = WRITE_BACK;
            end else begin
               // Invalidate before refilling so a partially filled line is
               // never seen as valid (e.g. after a reset mid-burst).
               vd_we      = 1'b1;
               state_next = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'({line_tag, st_idx, cnt_reg}) << OFF_W;
            mem_wdata = line_data;
            if (mem_ack) begin
               cnt_next = cnt_reg + WPL_W'(1);
               if (&cnt_reg) begin
                  vd_we      = 1'b1;
                  state_next = flushing_reg ? FLUSH_NEXT : ALLOCATE;
               end
            end
         end
         ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = ADDR_W'({req_tag_reg, st_idx, cnt_reg}) << OFF_W;
            if (mem_ack) begin
               data_we  = 1'b1;
               cnt_next = cnt_reg + WPL_W'(1);
               if (&cnt_reg) begin
                  tag_we     = 1'b1;
                  vd_we      = 1'b1;
                  wr_valid   = 1'b1;
                  state_next = LOOKUP;
               end
            end
         end
         FLUSH: begin
            cnt_next   = '0;
            state_next = (line_valid && line_dirty) ? WRITE_BACK : FLUSH_NEXT;
         end
         FLUSH_NEXT: begin
            vd_we = 1'b1;
            if (&flush_idx_reg) begin
               flush_done    = 1'b1;
               flushing_next = 1'b0;
               state_next    = IDLE;
            end else begin
               flush_idx_next = flush_idx_reg + IDX_W'(1);
               state_next     = FLUSH;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
module tb_cache_ctrl_wb;

   logic        clk, rst;
   logic        cpu_valid, cpu_ready, cpu_rw;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_wstrb;
   logic        cpu_resp_valid;
   logic        flush, flush_done;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int failures = 0;
   int max_delay = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } mop_t;
   mop_t log_q[$];
   logic [31:0] mem_model [logic [31:0]];

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          mdly;
      logic [31:0] exp_rdata;
      int          exp_lat;   // -1: not checked (random memory delay)
      int          exp_ops;   // 0 hit, 4 clean miss, 8 dirty miss
      logic [31:0] wb_base;
   } vec_t;

   cache_ctrl_wb dut (
      .iCLK(clk), .iRST(rst),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_rw(cpu_rw),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
      .flush(flush), .flush_done(flush_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {16'hA5A5, a[15:0]};
   endfunction

   // Memory responder: random ack delay, checks request stability.
   initial begin
      int delay_left;
      logic [31:0] h_addr, h_wdata;
      logic h_we;
      delay_left = -1;
      h_addr = '0; h_wdata = '0; h_we = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (rst || !mem_req) begin
            delay_left = -1;
         end else begin
            if (delay_left < 0) begin
               h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
               delay_left = (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
            end else begin
               chk("mem_addr_stable", mem_addr, h_addr);
               chk("mem_we_stable", {31'd0, mem_we}, {31'd0, h_we});
               if (h_we) chk("mem_wdata_stable", mem_wdata, h_wdata);
            end
            if (delay_left == 0) begin
               mem_ack = 1'b1;
               if (h_we) mem_model[h_addr] = h_wdata;
               else mem_rdata = mem_rd(h_addr);
               log_q.push_back('{h_we, h_addr, h_we ? h_wdata : mem_rd(h_addr)});
               delay_left = -1;
            end else begin
               delay_left--;
            end
         end
      end
   end

   task automatic run_vec(input vec_t v, input int k, output int start);
      int n, lat;
      logic got;
      logic [31:0] rd;
      max_delay = v.mdly;
      start = log_q.size();
      @(negedge clk);
      cpu_valid = 1'b1; cpu_rw = v.rw; cpu_addr = v.addr;
      cpu_wdata = v.wdata; cpu_wstrb = v.strb;
      n = 0;
      while (!cpu_ready && n < 50) begin @(negedge clk); n++; end
      chk($sformatf("v%0d_ready", k), {31'd0, cpu_ready}, 32'd1);
      @(posedge clk);
      #1 cpu_valid = 1'b0;
      lat = 0; got = 1'b0; rd = '0;
      while (!got && lat < 3000) begin
         @(negedge clk);
         lat++;
         if (cpu_resp_valid) begin got = 1'b1; rd = cpu_rdata; end
      end
      chk($sformatf("v%0d_resp", k), {31'd0, got}, 32'd1);
      if (!v.rw) chk($sformatf("v%0d_rdata", k), rd, v.exp_rdata);
      if (v.exp_lat >= 0) chk($sformatf("v%0d_latency", k), lat, v.exp_lat);
      chk($sformatf("v%0d_memops", k), log_q.size() - start, v.exp_ops);
      for (int i = 0; i < v.exp_ops && start + i < log_q.size(); i++) begin
         logic [31:0] ea;
         logic ewe;
         if (v.exp_ops == 8 && i < 4) begin
            ea = v.wb_base + 32'(4 * i); ewe = 1'b1;
         end else begin
            ea = (v.addr & ~32'hF) + 32'(4 * ((v.exp_ops == 8) ? i - 4 : i)); ewe = 1'b0;
         end
         chk($sformatf("v%0d_op%0d_addr", k, i), log_q[start + i].addr, ea);
         chk($sformatf("v%0d_op%0d_we", k, i), {31'd0, log_q[start + i].we}, {31'd0, ewe});
      end
      $display("txn v%0d rw=%0d addr=%h wdata=%h strb=%b rdata=%h lat=%0d memops=%0d",
               k, v.rw, v.addr, v.wdata, v.strb, rd, lat, log_q.size() - start);
   endtask

   initial begin
      vec_t tbl [13];
      int   vstart [13];
      logic [31:0] wb_exp [4];
      logic [31:0] fl_addr [8];
      logic [31:0] fl_data [8];
      int start, n, done_cnt, resp_cnt, extra;
      logic done_seen, found;

      //           rw    addr        wdata         strb    dly exp_rdata   lat ops wb_base
      tbl[0]  = '{1'b0, 32'h40,   32'h0,        4'b0000, 0, 32'h11111111, 6, 4, 32'h0};
      tbl[1]  = '{1'b0, 32'h48,   32'h0,        4'b0000, 0, 32'h33333333, 1, 0, 32'h0};
      tbl[2]  = '{1'b1, 32'h44,   32'hAABBCCDD, 4'b0011, 0, 32'h0,        1, 0, 32'h0};
      tbl[3]  = '{1'b0, 32'h44,   32'h0,        4'b0000, 0, 32'h2222CCDD, 1, 0, 32'h0};
      tbl[4]  = '{1'b0, 32'h1044, 32'h0,        4'b0000, 0, 32'h51515151, 10, 8, 32'h40};
      tbl[5]  = '{1'b1, 32'h1048, 32'hDEADBEEF, 4'b1111, 0, 32'h0,        1, 0, 32'h0};
      tbl[6]  = '{1'b1, 32'h2000, 32'h12345678, 4'b0000, 0, 32'h0,        6, 4, 32'h0};
      tbl[7]  = '{1'b0, 32'h2000, 32'h0,        4'b0000, 0, 32'hA5A52000, 1, 0, 32'h0};
      tbl[8]  = '{1'b0, 32'h40,   32'h0,        4'b0000, 0, 32'h11111111, 6, 4, 32'h0};
      tbl[9]  = '{1'b1, 32'h104C, 32'h12345678, 4'b1100, 5, 32'h0,       -1, 4, 32'h0};
      tbl[10] = '{1'b0, 32'h48,   32'h0,        4'b0000, 5, 32'h33333333, -1, 8, 32'h1040};
      tbl[11] = '{1'b0, 32'h104C, 32'h0,        4'b0000, 5, 32'h12345353, -1, 4, 32'h0};
      tbl[12] = '{1'b0, 32'h3040, 32'h0,        4'b0000, 0, 32'hA5A53040, 6, 4, 32'h0};

      wb_exp = '{32'h11111111, 32'h2222CCDD, 32'h33333333, 32'h44444444};
      fl_addr = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h1040, 32'h1044, 32'h1048, 32'h104C};
      fl_data = '{32'hA5A52000, 32'hA5A52004, 32'hA5A52008, 32'hA5A5200C,
                  32'h50505050, 32'h51515151, 32'hDEADBEEF, 32'h53535353};

      mem_model[32'h40] = 32'h11111111;   mem_model[32'h44] = 32'h22222222;
      mem_model[32'h48] = 32'h33333333;   mem_model[32'h4C] = 32'h44444444;
      mem_model[32'h1040] = 32'h50505050; mem_model[32'h1044] = 32'h51515151;
      mem_model[32'h1048] = 32'h52525252; mem_model[32'h104C] = 32'h53535353;

      rst = 1'b1; flush = 1'b0;
      cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
      chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) run_vec(tbl[k], k, vstart[k]);
      for (int i = 0; i < 4; i++)
         if (vstart[4] + i < log_q.size())
            chk($sformatf("v4_wb_data%0d", i), log_q[vstart[4] + i].data, wb_exp[i]);

      // Flush raised in the same cycle as a CPU request.
      start = log_q.size();
      @(negedge clk);
      flush = 1'b1; cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h40;
      #1 chk("flush_blocks_ready", {31'd0, cpu_ready}, 32'd0);
      n = 0; done_cnt = 0; resp_cnt = 0; extra = 0; done_seen = 1'b0;
      while (n < 1500 && extra < 6) begin
         @(negedge clk);
         n++;
         if (cpu_resp_valid) resp_cnt++;
         if (flush_done) begin
            done_cnt++;
            if (!done_seen) begin done_seen = 1'b1; flush = 1'b0; cpu_valid = 1'b0; end
         end
         if (done_seen) extra++;
      end
      chk("flush_done_pulses", done_cnt, 32'd1);
      chk("flush_no_cpu_resp", resp_cnt, 32'd0);
      chk("flush_write_count", log_q.size() - start, 32'd8);
      for (int i = 0; i < 8 && start + i < log_q.size(); i++) begin
         chk($sformatf("flush_wb%0d_addr", i), log_q[start + i].addr, fl_addr[i]);
         chk($sformatf("flush_wb%0d_data", i), log_q[start + i].data, fl_data[i]);
         chk($sformatf("flush_wb%0d_we", i), {31'd0, log_q[start + i].we}, 32'd1);
      end
      $display("txn flush writebacks=%0d done_pulses=%0d cycles=%0d", log_q.size() - start, done_cnt, n);

      for (int k = 8; k < 12; k++) run_vec(tbl[k], k, vstart[k]);
      if (vstart[10] + 3 < log_q.size()) begin
         chk("v10_wb_data2", log_q[vstart[10] + 2].data, 32'hDEADBEEF);
         chk("v10_wb_data3", log_q[vstart[10] + 3].data, 32'h12345353);
      end

      // Reset pulsed during the third refill word.
      max_delay = 0;
      @(negedge clk);
      cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h3040; cpu_wstrb = '0;
      @(posedge clk);
      #1 cpu_valid = 1'b0;
      n = 0; found = 1'b0;
      while (!found && n < 100) begin
         @(negedge clk);
         n++;
         if (mem_req && mem_addr == 32'h3048) found = 1'b1;
      end
      chk("rst_mid_found_word3", {31'd0, found}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mid_cpu_ready", {31'd0, cpu_ready}, 32'd1);
      chk("rst_mid_resp", {31'd0, cpu_resp_valid}, 32'd0);
      $display("txn reset asserted mid-refill at addr 3048");
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      run_vec(tbl[12], 12, vstart[12]);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
